// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the pipeline interlock: FSM state, control bundle and canned control words.
// Optional performance counters in hazard_stall_unit are enabled by HAZARD_PERF_CNT_EN.
package hazard_pkg;

  localparam int REG_AW    = 5;
  localparam int MDU_CNT_W = 8;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_hold;
    logic memwb_bubble;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '0;

  // Memory freeze: everything up to EX/MEM holds, ID/EX keeps its contents, MEM/WB drains a NOP.
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                         idex_bubble: 1'b0, exmem_hold: 1'b1, memwb_bubble: 1'b1};

  localparam pipe_ctrl_t CTRL_STALL = '{pc_hold: 1'b1, ifid_hold: 1'b1, ifid_flush: 1'b0,
                                        idex_bubble: 1'b1, exmem_hold: 1'b0, memwb_bubble: 1'b0};

  localparam pipe_ctrl_t CTRL_FLUSH = '{pc_hold: 1'b0, ifid_hold: 1'b0, ifid_flush: 1'b1,
                                        idex_bubble: 1'b1, exmem_hold: 1'b0, memwb_bubble: 1'b0};

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Bundle between the pipeline control path (master) and the interlock unit (slave).
// The perf-counter members exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_stall_unit_if #(
  parameter int REG_AW = hazard_pkg::REG_AW
);
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic              use_rs_id;
  logic              use_rt_id;
  logic              mdu_op_id;
  logic [REG_AW-1:0] dst_ex;
  logic              regwrite_ex;
  logic              memread_ex;
  logic              mdu_start_ex;
  logic              branch_taken_ex;
  logic              mem_req_mem;
  logic              mem_ready;

  logic              pc_hold;
  logic              ifid_hold;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              exmem_hold;
  logic              memwb_bubble;
  logic              mdu_busy;
  logic              mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_cycles;
`endif

  modport master (
`ifdef HAZARD_PERF_CNT_EN
    input  stall_cycles, flush_cycles,
`endif
    output rs_id, rt_id, use_rs_id, use_rt_id, mdu_op_id,
    output dst_ex, regwrite_ex, memread_ex, mdu_start_ex, branch_taken_ex,
    output mem_req_mem, mem_ready,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
    input  mdu_busy, mem_err
  );

  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    output stall_cycles, flush_cycles,
`endif
    input  rs_id, rt_id, use_rs_id, use_rt_id, mdu_op_id,
    input  dst_ex, regwrite_ex, memread_ex, mdu_start_ex, branch_taken_ex,
    input  mem_req_mem, mem_ready,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, exmem_hold, memwb_bubble,
    output mdu_busy, mem_err
  );

endinterface

// File: rtl/hazard_stall_unit_mdu_tracker.sv
// Countdown of the multi-cycle multiply/divide unit; busy stays high for exactly MDU_LAT cycles.
module hazard_mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic freeze,
  output logic busy
);

  localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);

  logic [MDU_CNT_W-1:0] mdu_cnt;

  // A frozen EX stage has not really issued its op, so the start is ignored until the freeze lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= '0;
      busy    <= 1'b0;
    end else if (start && !freeze) begin
      mdu_cnt <= CNT_LOAD;
      busy    <= 1'b1;
    end else if (busy) begin
      if (mdu_cnt == '0) begin
        busy <= 1'b0;
      end else begin
        mdu_cnt <= mdu_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Interlock unit for the 5-stage pipeline: load-use, MDU-busy and data-memory wait stalls.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_cycles counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = hazard_pkg::REG_AW,
  parameter int MDU_LAT     = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_unit_if.slave bus
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err;
  logic              mdu_busy;

  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] dst;
  logic              mem_stall;
  logic              timeout;
  logic              freeze;
  logic              load_use;
  logic              mdu_conflict;
  pipe_ctrl_t        ctrl;

  assign rs  = bus.rs_id;
  assign rt  = bus.rt_id;
  assign dst = bus.dst_ex;

  assign mem_stall = bus.mem_req_mem && !bus.mem_ready;
  assign timeout   = (state == MEM_WAIT) && !bus.mem_ready && (wait_cnt == WAIT_LAST);
  assign freeze    = (state == RUN) ? mem_stall : (!bus.mem_ready && !timeout);

  assign load_use = bus.memread_ex && bus.regwrite_ex && (dst != '0) &&
                    ((bus.use_rs_id && (rs == dst)) || (bus.use_rt_id && (rt == dst)));
  assign mdu_conflict = bus.mdu_op_id && mdu_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (bus.mem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (timeout) begin
            // Give up on the access: flag it and let the pipeline move on.
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b1;
          end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so an abort takes effect without a clock.
  always_comb begin
    ctrl = CTRL_NONE;
    if (!rst_n) begin
      ctrl = CTRL_NONE;
    end else if (freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (bus.branch_taken_ex) begin
      ctrl = CTRL_FLUSH;
    end else if (load_use || mdu_conflict) begin
      ctrl = CTRL_STALL;
    end
  end

  hazard_mdu_tracker #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (bus.mdu_start_ex),
    .freeze (freeze),
    .busy   (mdu_busy)
  );

  assign bus.pc_hold      = ctrl.pc_hold;
  assign bus.ifid_hold    = ctrl.ifid_hold;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_bubble  = ctrl.idex_bubble;
  assign bus.exmem_hold   = ctrl.exmem_hold;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.mdu_busy     = mdu_busy;
  assign bus.mem_err      = mem_err;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (ctrl.pc_hold)    stall_cycles <= stall_cycles + 32'd1;
      if (ctrl.ifid_flush) flush_cycles <= flush_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles;
  assign bus.flush_cycles = flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed hazard scenarios followed by random traffic.
module tb_hazard_stall_unit;

  localparam int MDU_LAT     = 4;
  localparam int MEM_TIMEOUT = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       mdu_op;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
    logic       mdu_start;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hazard_stall_unit_if #(.REG_AW(5)) hz ();

  hazard_stall_unit #(
    .REG_AW      (5),
    .MDU_LAT     (MDU_LAT),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hz)
  );

  always #5 clk = ~clk;

  // Scoreboard
  logic [7:0] exp_q[$];
  string      tag_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model state: spec-level quantities
  bit in_wait;
  int waited;
  bit err;
  int mdu_left;

  function automatic logic [7:0] observed();
    return {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.idex_bubble,
            hz.exmem_hold, hz.memwb_bubble, hz.mdu_busy, hz.mem_err};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] a;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = observed();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got pc/ifh/fl/bub/exh/mwb/busy/err=%b want %b at %0t", t, a, e, $time);
      end
    end
  end

  // Called #1 after a rising edge: apply inputs, predict this cycle, advance model across the next edge.
  task automatic step(input string tag, input logic rst_v, input stim_t s);
    bit busy, frz, tmo, lu, mc;
    bit pc, ifh, fl, bub, exh, mwb;
    rst_n              = rst_v;
    hz.rs_id           = s.rs;
    hz.rt_id           = s.rt;
    hz.use_rs_id       = s.use_rs;
    hz.use_rt_id       = s.use_rt;
    hz.mdu_op_id       = s.mdu_op;
    hz.dst_ex          = s.dst;
    hz.regwrite_ex     = s.regwrite;
    hz.memread_ex      = s.memread;
    hz.mdu_start_ex    = s.mdu_start;
    hz.branch_taken_ex = s.branch;
    hz.mem_req_mem     = s.mem_req;
    hz.mem_ready       = s.mem_ready;
    if (!rst_v) begin
      in_wait = 0; waited = 0; err = 0; mdu_left = 0;
      exp_q.push_back(8'h00);
      tag_q.push_back(tag);
    end else begin
      busy = (mdu_left > 0);
      if (!in_wait) begin
        tmo = 0;
        frz = s.mem_req && !s.mem_ready;
      end else begin
        tmo = !s.mem_ready && (waited == MEM_TIMEOUT - 1);
        frz = !s.mem_ready && !tmo;
      end
      lu = s.memread && s.regwrite && (s.dst != 0) &&
           ((s.use_rs && s.rs == s.dst) || (s.use_rt && s.rt == s.dst));
      mc = s.mdu_op && busy;
      {pc, ifh, fl, bub, exh, mwb} = '0;
      if (frz)           {pc, ifh, exh, mwb} = 4'hF;
      else if (s.branch) {fl, bub} = 2'b11;
      else if (lu || mc) {pc, ifh, bub} = 3'b111;
      exp_q.push_back({pc, ifh, fl, bub, exh, mwb, busy, err});
      tag_q.push_back(tag);
      if (!in_wait) begin
        if (frz) begin in_wait = 1; waited = 0; end
      end else if (s.mem_ready) begin
        in_wait = 0;
      end else if (tmo) begin
        in_wait = 0; err = 1;
      end else begin
        waited++;
      end
      if (s.mdu_start && !frz) mdu_left = MDU_LAT;
      else if (mdu_left > 0)   mdu_left--;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.mem_ready = 1'b1;
    return s;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    hz.rs_id = '0; hz.rt_id = '0; hz.use_rs_id = 0; hz.use_rt_id = 0; hz.mdu_op_id = 0;
    hz.dst_ex = '0; hz.regwrite_ex = 0; hz.memread_ex = 0; hz.mdu_start_ex = 0;
    hz.branch_taken_ex = 0; hz.mem_req_mem = 0; hz.mem_ready = 1;
    @(posedge clk);
    #1;

    // Reset with hazards present on the inputs: every output must stay low
    s = idle(); s.mem_req = 1; s.mem_ready = 0; s.branch = 1; s.memread = 1;
    repeat (2) step("reset", 1'b0, s);
    step("idle", 1'b1, idle());

    s = idle(); s.memread = 1; s.regwrite = 1; s.dst = 5; s.use_rs = 1; s.rs = 5;
    step("load_use", 1'b1, s);
    step("load_use_after", 1'b1, idle());
    s = idle(); s.memread = 1; s.regwrite = 1; s.dst = 0; s.use_rs = 1; s.rs = 0;
    step("load_use_r0", 1'b1, s);
    s = idle(); s.memread = 1; s.regwrite = 1; s.dst = 9; s.use_rt = 1; s.rt = 9;
    step("load_use_rt", 1'b1, s);

    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (3) step("mem_wait", 1'b1, s);
    s.mem_ready = 1;
    step("mem_wait_release", 1'b1, s);
    step("mem_wait_after", 1'b1, idle());

    s = idle(); s.branch = 1; s.memread = 1; s.regwrite = 1; s.dst = 7; s.use_rs = 1; s.rs = 7;
    step("branch_over_load_use", 1'b1, s);
    s = idle(); s.branch = 1; s.mem_req = 1; s.mem_ready = 0;
    step("freeze_over_branch", 1'b1, s);
    s.mem_ready = 1;
    step("freeze_release_branch", 1'b1, s);

    s = idle(); s.mdu_start = 1;
    step("mdu_start", 1'b1, s);
    s = idle(); s.mdu_op = 1;
    repeat (6) step("mdu_conflict", 1'b1, s);

    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (5) step("mem_timeout", 1'b1, s);
    repeat (3) step("mem_err_sticky", 1'b1, idle());

    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    step("reset_clear_err", 1'b0, idle());
    repeat (2) step("pre_abort_wait", 1'b1, s);
    step("reset_mid_wait", 1'b0, s);
    s = idle(); s.mem_ready = 0;
    repeat (2) step("run_after_reset", 1'b1, s);

    for (int i = 0; i < 3000; i++) begin
      s.rs        = 5'($urandom_range(0, 7));
      s.rt        = 5'($urandom_range(0, 7));
      s.use_rs    = ($urandom_range(0, 99) < 60);
      s.use_rt    = ($urandom_range(0, 99) < 40);
      s.mdu_op    = ($urandom_range(0, 99) < 30);
      s.dst       = 5'($urandom_range(0, 7));
      s.regwrite  = ($urandom_range(0, 99) < 80);
      s.memread   = ($urandom_range(0, 99) < 30);
      s.mdu_start = (mdu_left == 0) && ($urandom_range(0, 99) < 10);
      s.branch    = ($urandom_range(0, 99) < 15);
      s.mem_req   = ($urandom_range(0, 99) < 40);
      s.mem_ready = ($urandom_range(0, 99) < 65);
      step("random", ($urandom_range(0, 99) != 0), s);
    end

    step("drain", 1'b1, idle());
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Interlock side of the 5-stage MIPS hazard logic; complements the forwarding unit.
- Covers the hazards bypassing cannot resolve: load-use, data-memory wait states, and the multi-cycle multiply/divide unit (MDU) being busy.
- Produces hold, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits beside the forwarding unit, between the pipeline registers and the control path.

Parameters:
- REG_AW, 5, register address width.
- MDU_LAT, 32, MDU cycles from start to result; range 2..255.
- MEM_TIMEOUT, 64, maximum wait cycles before mem_err is raised; range 1..1023.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_id  in  REG_AW  ID-stage source 0 address.
- rt_id  in  REG_AW  ID-stage source 1 address.
- use_rs_id  in  1  ID instruction reads rs.
- use_rt_id  in  1  ID instruction reads rt.
- mdu_op_id  in  1  ID instruction is an MDU op or reads HI/LO.
- dst_ex  in  REG_AW  EX-stage destination.
- regwrite_ex  in  1  EX instruction writes a register.
- memread_ex  in  1  EX instruction is a load.
- mdu_start_ex  in  1  EX instruction launches an MDU op.
- branch_taken_ex  in  1  branch/jump resolved taken in EX.
- mem_req_mem  in  1  MEM stage accesses data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_hold  out  1  EX/MEM keeps its value.
- memwb_bubble  out  1  MEM/WB loads a NOP.
- mdu_busy  out  1  MDU occupied.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs 0; FSM in RUN; mdu_cnt=0; wait_cnt=0.
  - Reset mid-stall aborts the stall immediately.
- FSM state is registered. Control outputs are combinational from the current state and inputs, so they act in the same cycle as the hazard.
- RUN state:
  - Memory wait: if mem_req_mem && !mem_ready, freeze this cycle and go to MEM_WAIT next cycle.
  - Freeze means pc_hold=ifid_hold=exmem_hold=1, idex_bubble=0 (ID/EX holds), memwb_bubble=1.
- MEM_WAIT state:
  - Freeze every cycle while mem_ready=0; wait_cnt increments.
  - mem_ready=1: no freeze this cycle; return to RUN next cycle; clear wait_cnt.
  - wait_cnt reaching MEM_TIMEOUT-1 without mem_ready: set mem_err (cleared only by reset), release the freeze, return to RUN.
- Priority when no freeze is active (highest first):
  1. branch_taken_ex: ifid_flush=1, idex_bubble=1. Holds are suppressed.
  2. Load-use: memread_ex && regwrite_ex && dst_ex!=0 && ((use_rs_id && rs_id==dst_ex) || (use_rt_id && rt_id==dst_ex)). Drives pc_hold=ifid_hold=idex_bubble=1 for exactly one cycle; the next cycle resolves through MEM forwarding.
  3. MDU conflict: mdu_op_id && mdu_busy drives pc_hold=ifid_hold=idex_bubble=1.
- A freeze overrides every other control. ifid_flush and idex_bubble are 0 during a freeze.
- MDU counter:
  - mdu_start_ex while not frozen loads mdu_cnt=MDU_LAT-1 and sets mdu_busy=1 next cycle.
  - mdu_cnt decrements each cycle, including during a freeze.
  - mdu_busy drops the cycle after mdu_cnt reaches 0.
  - A start while busy cannot occur, because the conflict stall blocks it.
- Width rules: mdu_cnt is 8 bits; wait_cnt is clog2(MEM_TIMEOUT)+1 bits. Neither counter wraps: both saturate at their terminal value.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on any cycle with pc_hold=1.
  - flush_cycles increments on any cycle with ifid_flush=1.
  - Both wrap modulo 2^32 and reset to 0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - the state enum {RUN, MEM_WAIT};
  - REG_AW;
  - a pipe_ctrl_t struct bundling the six hold/bubble/flush bits, for reuse by the pipeline top.
- One natural sub-module: hazard_mdu_tracker, containing the MDU countdown and mdu_busy.

Test Plan:
- Load-use hazard: lw $5 in EX (memread_ex=1, dst_ex=5), ID reads rs=5 -> one cycle with pc_hold=ifid_hold=idex_bubble=1, then all 0. Repeat with dst_ex=0 -> no stall.
- Memory wait: mem_req_mem=1 with mem_ready low for 3 cycles -> freeze for exactly 3 cycles; releases in the mem_ready cycle; mem_err stays 0.
- Memory timeout: MEM_TIMEOUT=4, mem_ready never asserted -> mem_err=1 after 4 freeze cycles; freeze releases; mem_err persists until rst_n=0.
- MDU conflict: MDU_LAT=4, mdu_start_ex, then mdu_op_id=1 -> mdu_busy high for 4 cycles; stall lasts until mdu_busy falls.
- Simultaneous hazards: branch_taken_ex together with a load-use match -> ifid_flush=idex_bubble=1, pc_hold=0. Freeze together with a branch -> freeze only.
- Asynchronous reset: rst_n low mid-MEM_WAIT -> all outputs 0 immediately; state is RUN after release.
